// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer
//   Buffers KERNAL_SIZE rows of a raster pixel stream in a two-bank ping-pong
//   store and replays every non-overlapping KERNAL_SIZE x KERNAL_SIZE window
//   serially, tagged with its element index, to the pooling stage.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low clear
//   restart       synchronous clear of pointers, flags and output register
//   layer_active  gates the input side; the output side keeps draining
//   in_valid / in_ready / in_data        pixel input (NUM_NODES channels)
//   out_valid / out_ready / out_data     window element output
//   out_count     element index inside the window (ky*KERNAL_SIZE + kx)
//   out_first     out_count == 0
//   out_last      out_count == KERNAL_SIZE**2-1
module pool_window_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_NODES   = 16,
    parameter int KERNAL_SIZE = 2,
    parameter int IMG_WIDTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 restart,
    input  logic                                 layer_active,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_NODES*DATA_WIDTH-1:0]      in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_NODES*DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(KERNAL_SIZE**2)-1:0]    out_count,
    output logic                                 out_first,
    output logic                                 out_last
);

    localparam int BW    = NUM_NODES * DATA_WIDTH;
    localparam int DEPTH = KERNAL_SIZE * IMG_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(KERNAL_SIZE);
    localparam int CW    = $clog2(KERNAL_SIZE * KERNAL_SIZE);
    localparam int NWIN  = IMG_WIDTH / KERNAL_SIZE;
    localparam int XW    = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic [BW-1:0] mem [2][DEPTH];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wr_bank;
    logic          rd_bank;   // bank of the element sitting in the output register
    logic          iss_bank;  // bank the window counters are walking
    logic [AW-1:0] wr_addr;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic [XW-1:0] wx;
    logic          out_end;   // output register holds the final element of its bank

    logic          wr_fire;
    logic          wr_done;
    logic          wr_bank_nxt;
    logic          out_fire;
    logic          rel;
    logic          load;
    logic          win_done;
    logic          iss_end;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_cnt;

    assign wr_fire     = in_valid && in_ready;
    assign wr_done     = wr_fire && (wr_addr == AW'(DEPTH - 1));
    assign wr_bank_nxt = wr_bank ^ wr_done;
    assign out_fire    = out_valid && out_ready;
    assign rel         = out_fire && out_end;
    // Issue is decoupled from release: once a bank's last element is loaded
    // the counters move to the other bank, so a bank that is already full is
    // streamed back-to-back with no bubble.
    assign load        = full[iss_bank] && (!out_valid || out_ready);
    assign win_done    = (kx == KW'(KERNAL_SIZE - 1)) && (ky == KW'(KERNAL_SIZE - 1));
    assign iss_end     = win_done && (wx == XW'(NWIN - 1));
    assign rd_addr     = AW'(int'(ky) * IMG_WIDTH + int'(wx) * KERNAL_SIZE + int'(kx));
    assign rd_cnt      = CW'(int'(ky) * KERNAL_SIZE + int'(kx));

    // Set and clear always target different banks, so both can apply at once.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rel)     full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_addr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            iss_bank  <= 1'b0;
            wr_addr   <= '0;
            kx        <= '0;
            ky        <= '0;
            wx        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_end   <= 1'b0;
        end else if (restart) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            iss_bank  <= 1'b0;
            wr_addr   <= '0;
            kx        <= '0;
            ky        <= '0;
            wx        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_end   <= 1'b0;
        end else begin
            full     <= full_nxt;
            // Registered ready looks at the post-edge bank state so a writer
            // stalls the cycle after the completing beat and resumes the
            // cycle after a release.
            in_ready <= layer_active && !full_nxt[wr_bank_nxt];

            if (wr_fire) wr_addr <= wr_done ? '0 : wr_addr + AW'(1);
            if (wr_done) wr_bank <= ~wr_bank;
            if (rel)     rd_bank <= ~rd_bank;

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[iss_bank][rd_addr];
                out_count <= rd_cnt;
                out_first <= (kx == '0) && (ky == '0);
                out_last  <= win_done;
                out_end   <= iss_end;
                if (kx == KW'(KERNAL_SIZE - 1)) begin
                    kx <= '0;
                    if (ky == KW'(KERNAL_SIZE - 1)) begin
                        ky <= '0;
                        wx <= (wx == XW'(NWIN - 1)) ? '0 : wx + XW'(1);
                    end else begin
                        ky <= ky + KW'(1);
                    end
                end else begin
                    kx <= kx + KW'(1);
                end
                if (iss_end) iss_bank <= ~iss_bank;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_sequencer.sv
module tb_pool_window_sequencer;

    localparam int DW    = 16;
    localparam int NN    = 4;
    localparam int K     = 2;
    localparam int W     = 4;
    localparam int BW    = NN * DW;
    localparam int DEPTH = K * W;
    localparam int E     = K * K;
    localparam int CW    = $clog2(E);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          restart = 1'b0;
    logic          layer_active = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_first;
    logic          out_last;

    pool_window_sequencer #(
        .DATA_WIDTH(DW), .NUM_NODES(NN), .KERNAL_SIZE(K), .IMG_WIDTH(W)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .layer_active(layer_active),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Hand-derived 2x2 / width-4 window order and element indices.
    int perm[8]    = '{0, 1, 4, 5, 2, 3, 6, 7};
    int cnt_lit[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0] d;
        int            c;
        int            avail;  // earliest negedge index the element may be shown
    } ent_t;

    ent_t          exp_q[$];
    logic [BW-1:0] pix_q[$];
    int            occ = 0;    // completed banks not yet fully consumed
    int            nout = 0;
    int            cyc = 0;
    logic          pred_ir = 1'b0;
    logic          prev_ov = 1'b0, prev_or = 1'b0, prev_f = 1'b0, prev_l = 1'b0, prev_ir = 1'b0;
    logic [BW-1:0] prev_d = '0;
    logic [CW-1:0] prev_c = '0;

    logic [DW-1:0] got_d[$];
    int            got_c[$];
    logic          got_l[$];
    int            got_cyc[$];
    int            in_hs_cnt = 0, in_hs_cyc = 0, first_ov_cyc = -1, ir_rise_cyc = -1;
    int            or_mode = 0, or_ph = 0;

    task automatic model_clear();
        exp_q.delete();
        pix_q.delete();
        occ = 0;
        nout = 0;
        pred_ir = 1'b0;
        prev_ov = 1'b0;
    endtask

    task automatic push_bank(input int c);
        for (int j = 0; j < DEPTH; j++) begin
            ent_t e;
            int wx, r, ky, kx;
            wx = j / E;
            r  = j % E;
            ky = r / K;
            kx = r % K;
            e.d = pix_q[ky * W + wx * K + kx];
            e.c = r;
            e.avail = c + 2;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            model_clear();
            prev_ir = 1'b0;
        end else begin
            chk("in_ready", in_ready, pred_ir);
            if (prev_ov && !prev_or) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_d);
                chk("hold_count", out_count, prev_c);
                chk("hold_first", out_first, prev_f);
                chk("hold_last", out_last, prev_l);
            end
            if (exp_q.size() == 0) begin
                chk("out_valid_idle", out_valid, 1'b0);
            end else begin
                chk("out_valid", out_valid, exp_q[0].avail <= cyc);
                if (out_valid) begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_count", out_count, exp_q[0].c);
                    chk("out_first", out_first, exp_q[0].c == 0);
                    chk("out_last", out_last, exp_q[0].c == E - 1);
                end
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (in_ready && !prev_ir && ir_rise_cyc < 0) ir_rise_cyc = cyc;
            prev_ir = in_ready;
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_d  = out_data;
            prev_c  = out_count;
            prev_f  = out_first;
            prev_l  = out_last;
            if (restart) begin
                model_clear();
            end else begin
                if (out_valid && out_ready) begin
                    got_d.push_back(out_data[DW-1:0]);
                    got_c.push_back(int'(out_count));
                    got_l.push_back(out_last);
                    got_cyc.push_back(cyc);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (exp_q.size() > 0) begin
                        ent_t h;
                        h = exp_q.pop_front();
                        if (h.avail < cyc + 1) h.avail = cyc + 1;
                        exp_q.push_front(h);
                    end
                    nout++;
                    if (nout == DEPTH) begin
                        nout = 0;
                        occ--;
                    end
                end
                if (in_valid && in_ready) begin
                    in_hs_cnt++;
                    in_hs_cyc = cyc;
                    pix_q.push_back(in_data);
                    if (pix_q.size() == DEPTH) begin
                        push_bank(cyc);
                        pix_q.delete();
                        occ++;
                    end
                end
                pred_ir = layer_active && (occ < 2);
            end
        end
    end

    // out_ready pattern generator for backpressure / random phases
    always @(posedge clk) begin
        #1;
        if (or_mode == 1) begin
            out_ready = ((or_ph % 4) == 0) || ((or_ph % 4) == 3);
            or_ph++;
        end else if (or_mode == 2) begin
            out_ready = ($urandom % 3) != 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] pix(input int v);
        logic [BW-1:0] r;
        r = {$urandom(), $urandom()};
        r[DW-1:0] = DW'(v);
        return r;
    endfunction

    task automatic send_pixel(input logic [BW-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 300) begin
            tick();
            t++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (got_d.size() < n && t < 500) begin
            tick();
            t++;
        end
        chk("drain_count", got_d.size(), n);
    endtask

    task automatic clear_log();
        got_d.delete();
        got_c.delete();
        got_l.delete();
        got_cyc.delete();
        first_ov_cyc = -1;
    endtask

    task automatic check_window(input string nm, input int base, input int off);
        for (int i = 0; i < 8; i++) begin
            if (off + i < got_d.size()) chk(nm, got_d[off + i], base + perm[i]);
            else chk({nm, "_missing"}, got_d.size(), off + i + 1);
        end
    endtask

    initial begin
        int n0;
        int t;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", out_count, '0);
        chk("rst_out_first", out_first, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        reset = 1'b1;
        layer_active = 1'b1;
        out_ready = 1'b1;
        tick();

        // basic ordering and latency
        clear_log();
        for (int i = 0; i < 8; i++) send_pixel(pix(i));
        wait_outs(8);
        check_window("basic", 0, 0);
        for (int i = 0; i < 8 && i < got_c.size(); i++) begin
            chk("basic_count", got_c[i], cnt_lit[i]);
            chk("basic_last", got_l[i], (i == 3) || (i == 7));
        end
        chk("basic_latency", first_ov_cyc - in_hs_cyc, 2);

        // backpressure 1,0,0,1
        clear_log();
        or_ph = 0;
        or_mode = 1;
        for (int i = 0; i < 8; i++) send_pixel(pix(16 + i));
        wait_outs(8);
        or_mode = 0;
        out_ready = 1'b1;
        check_window("bp", 16, 0);

        // ping-pong stall
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_pixel(pix(32 + i));
        chk("pp_stall", in_ready, 1'b0);
        ir_rise_cyc = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) send_pixel(pix(48 + i));
            end
            begin
                repeat (4) tick();
                out_ready = 1'b1;
            end
        join
        wait_outs(24);
        if (got_cyc.size() >= 8) chk("pp_release", ir_rise_cyc - got_cyc[7], 1);
        check_window("pp0", 32, 0);
        check_window("pp1", 40, 8);
        check_window("pp2", 48, 16);

        // layer_active low mid-row
        clear_log();
        send_pixel(pix(64));
        send_pixel(pix(65));
        layer_active = 1'b0;
        tick();
        n0 = in_hs_cnt;
        in_valid = 1'b1;
        in_data = pix(66);
        repeat (3) begin
            chk("la_ready", in_ready, 1'b0);
            tick();
        end
        chk("la_no_accept", in_hs_cnt, n0);
        layer_active = 1'b1;
        for (int i = 2; i < 8; i++) send_pixel(pix(64 + i));
        wait_outs(8);
        check_window("la", 64, 0);

        // restart mid-frame
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) send_pixel(pix(128 + i));
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("rs_two_beats", got_d.size(), 2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_out_data", out_data, '0);
        chk("rs_out_count", out_count, '0);
        chk("rs_out_first", out_first, 1'b0);
        chk("rs_out_last", out_last, 1'b0);
        chk("rs_in_ready", in_ready, 1'b0);
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_pixel(pix(100 + i));
        wait_outs(8);
        check_window("restart", 100, 0);

        // async reset mid-drain
        clear_log();
        or_ph = 0;
        or_mode = 1;
        for (int i = 0; i < 8; i++) send_pixel(pix(200 + i));
        t = 0;
        while (got_d.size() < 3 && t < 200) begin
            tick();
            t++;
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b0);
        or_mode = 0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
        for (int i = 0; i < 8; i++) send_pixel(pix(210 + i));
        wait_outs(8);
        check_window("after_reset", 210, 0);

        // randomized traffic
        or_mode = 2;
        repeat (800) begin
            in_valid = ($urandom % 4) != 0;
            in_data = {$urandom(), $urandom()};
            layer_active = ($urandom % 16) != 0;
            restart = ($urandom % 200) == 0;
            tick();
        end
        restart = 1'b0;
        in_valid = 1'b0;
        layer_active = 1'b1;
        or_mode = 0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
- Sits directly upstream of the pooling stage.
- Accepts the previous layer's raster-order pixel stream (NUM_NODES channels in parallel per beat) and buffers KERNAL_SIZE rows in a ping-pong bank.
- Replays each non-overlapping KERNAL_SIZE x KERNAL_SIZE window serially, with an element index, so each pooling node reduces one window per KERNAL_SIZE**2 beats.

Parameters:
- DATA_WIDTH, 16, bits per channel value
- NUM_NODES, 16, channels carried in parallel per beat
- KERNAL_SIZE, 2, window edge; stride equals KERNAL_SIZE; must be >= 2
- IMG_WIDTH, 8, pixels per row; must be a multiple of KERNAL_SIZE

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- restart  in  1  synchronous clear of pointers and bank flags (same effect as reset, takes effect at the clock edge)
- layer_active  in  1  when 0, input side accepts nothing; output side keeps draining
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  NUM_NODES*DATA_WIDTH  one pixel, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  NUM_NODES*DATA_WIDTH  one window element, same packing
- out_count  out  $clog2(KERNAL_SIZE**2)  element index within window, 0..KERNAL_SIZE**2-1
- out_first  out  1  out_count == 0
- out_last  out  1  out_count == KERNAL_SIZE**2-1

Behaviour:
- Storage: two banks, each KERNAL_SIZE*IMG_WIDTH entries of NUM_NODES*DATA_WIDTH bits. Per-bank full flag; wr_bank and rd_bank pointers.
- Reset/restart values: in_ready=0, out_valid=0, out_data=0, out_count=0, out_first=0, out_last=0; both full flags 0; wr_bank=rd_bank=0; all indices 0. Stored data need not be cleared.
- in_ready is registered:
  - It equals layer_active && !full[wr_bank] as of the previous edge.
  - It drops the cycle after the bank-completing beat.
- Write side: accepted beats fill wr_bank at addresses 0..KERNAL_SIZE*IMG_WIDTH-1, in raster order.
- Bank completion: on the edge that accepts the last address, set full[wr_bank], toggle wr_bank, and reset the write address to 0.
- Read side: while full[rd_bank], iterate windows in this nested order:
  - wx = 0..IMG_WIDTH/KERNAL_SIZE-1 (outermost)
  - ky = 0..KERNAL_SIZE-1
  - kx = 0..KERNAL_SIZE-1 (innermost)
  - read address = ky*IMG_WIDTH + wx*KERNAL_SIZE + kx; out_count = ky*KERNAL_SIZE + kx.
- Output latency:
  - Bank full flag set at edge N: first out_valid is visible after edge N+1.
  - With out_ready held 1, one beat is produced per cycle with no bubbles, including across window boundaries and across banks when the next bank is already full.
- Output hold rule: while out_valid && !out_ready, out_data, out_count, out_first and out_last stay stable. out_valid never drops without a handshake, except on reset or restart.
- Bank release: the handshake of the final element of the final window clears full[rd_bank] and toggles rd_bank. A stalled writer sees in_ready=1 on the following cycle.
- Simultaneous set/clear on different banks in the same cycle: both take effect.
- Both banks full: in_ready=0 until one bank is released.
- layer_active=0: in_ready goes 0 at the next edge; a beat already presented with in_ready=1 in that cycle is still accepted.
- Restart or reset mid-frame: partial bank contents are discarded and the output beat in flight is dropped. After the edge, the next accepted beat is written to bank 0 address 0.
- Arithmetic: no data modification. Counters use $clog2 widths; all index wraps are exact, with no out-of-range address ever generated.

Test Plan:
- Basic 2x2, W=4 (KERNAL_SIZE=2, IMG_WIDTH=4, restrict to this config): stream ch0 values 0..7, out_ready=1.
  - Required: out_data ch0 = 0,1,4,5,2,3,6,7.
  - Required: out_count = 0,1,2,3,0,1,2,3; out_last on the 4th and 8th beats.
  - Required: first out_valid two edges after the 8th input handshake.
- Backpressure: same stream, out_ready toggling 1,0,0,1 ...
  - Required: no value skipped or duplicated.
  - Required: out_data/out_count held constant during every low cycle.
- Ping-pong stall: stream 24 pixels with out_ready=0.
  - Required: in_ready=0 after the 16th accepted pixel.
  - Required: after out_ready goes 1, in_ready returns one cycle after the 8th output handshake.
  - Required: 24 window elements total, in order.
- layer_active low for 3 cycles mid-row: no input accepted during those cycles; the output window ordering is unchanged.
- Restart after 5 input pixels and 2 output beats:
  - Required: outputs clear on the next edge.
  - Required: fresh stream 100..107 yields 100,101,104,105,102,103,106,107.
- Asynchronous reset asserted mid-drain between clock edges:
  - Required: out_valid=0 and in_ready=0 immediately, before the next clock edge.
  - Required: after deassertion, normal operation resumes from bank 0.
